// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Supports freeze (stall), flush (bubble insert) and a saturating flush-discard counter.
module pipe_stage_skid_reg #(
  parameter int unsigned          PC_W         = 32,
  parameter int unsigned          INSTR_W      = 32,
  parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = '0,
  parameter int unsigned          CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   kill_cnt
);

  localparam int unsigned      SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic push;
  logic pop;
  logic load_head_in;
  logic load_head_skid;
  logic load_skid;

  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [SUM_W-1:0]   kill_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; freeze needs no term since it forces push = pop = 0
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (!push && pop) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake and datapath-load decodes; in_ready looks only at registered state
  always_comb begin
    in_ready       = (state != FULL) && !freeze && !flush && !rst;
    out_valid      = (state != EMPTY) && !freeze;
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    load_head_in   = push && ((state == EMPTY) || ((state == ONE) && pop));
    load_skid      = push && (state == ONE) && !pop;
    load_head_skid = pop && (state == FULL);
  end

  // Head and skid entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instruction <= BUBBLE_INSTR;
      skid_pc     <= '0;
      skid_instr  <= '0;
    end else if (flush) begin
      pc          <= '0;
      instruction <= BUBBLE_INSTR;
    end else begin
      if (load_head_in) begin
        pc          <= pc_in;
        instruction <= instr_in;
      end else if (load_head_skid) begin
        pc          <= skid_pc;
        instruction <= skid_instr;
      end
      if (load_skid) begin
        skid_pc    <= pc_in;
        skid_instr <= instr_in;
      end
    end
  end

  assign occupancy = 2'(state);
  assign kill_sum  = SUM_W'(kill_cnt) + SUM_W'(occupancy);

  // Discarded-entry counter saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_cnt <= '0;
    end else if (flush) begin
      kill_cnt <= (kill_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : kill_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: queue scoreboard plus directed
// checks for reset, backpressure, freeze, flush, counter saturation and mid-run reset.
module tb_pipe_stage_skid_reg;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam logic [31:0] MASK   = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc_in, instr_in, pc, instruction;
  logic [1:0]  occupancy;
  logic [1:0]  kill_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int          kcnt;
  bit          bubble;

  pipe_stage_skid_reg #(
    .PC_W(32), .INSTR_W(32), .BUBBLE_INSTR(BUBBLE), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .instruction(instruction),
    .occupancy(occupancy), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the scoreboard, advance the model
  task automatic cyc(input logic r, input logic fz, input logic fl, input logic iv,
                     input logic [31:0] p, input logic ordy);
    logic exp_ready, exp_valid;
    rst = r; freeze = fz; flush = fl; in_valid = iv;
    pc_in = p; instr_in = p ^ MASK; out_ready = ordy;
    #1;
    exp_ready = (q.size() != 2) && !fz && !fl && !r;
    exp_valid = (q.size() != 0) && !fz;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("kill_cnt", 64'(kill_cnt), 64'(kcnt));
    if (q.size() != 0) begin
      chk("pc", 64'(pc), 64'(q[0]));
      chk("instruction", 64'(instruction), 64'(q[0] ^ MASK));
    end else if (bubble) begin
      chk("pc_bubble", 64'(pc), 64'd0);
      chk("instr_bubble", 64'(instruction), 64'(BUBBLE));
    end
    @(posedge clk);
    if (r) begin
      q.delete(); kcnt = 0; bubble = 1'b1;
    end else if (fl) begin
      kcnt = (kcnt + q.size() > 3) ? 3 : kcnt + q.size();
      q.delete(); bubble = 1'b1;
    end else begin
      if (exp_valid && ordy) void'(q.pop_front());
      if (exp_ready && iv) begin
        q.push_back(p); bubble = 1'b0;
      end
    end
    #1;
  endtask

  int sat_exp[5] = '{2, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
    pc_in = '0; instr_in = '0; out_ready = 1'b0;
    kcnt = 0; bubble = 1'b1;
    @(posedge clk); #1;

    // Reset state
    cyc(1, 0, 0, 0, 32'h0, 0);

    // 1: single-cycle latency from an empty stage
    cyc(0, 0, 0, 1, 32'h100, 1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", 64'(pc), 64'h100);
    cyc(0, 0, 0, 0, 32'h0, 1);

    // 2: backpressure fills the skid, then drains in order
    cyc(0, 0, 0, 1, 32'h100, 0);
    cyc(0, 0, 0, 1, 32'h104, 0);
    chk("t2_full", 64'(occupancy), 64'd2);
    cyc(0, 0, 0, 1, 32'h108, 0);
    cyc(0, 0, 0, 1, 32'h108, 1);
    cyc(0, 0, 0, 1, 32'h108, 1);
    cyc(0, 0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 0, 32'h0, 1);

    // 3: freeze with out_ready high pops nothing
    cyc(0, 0, 0, 1, 32'h100, 0);
    cyc(0, 0, 0, 1, 32'h104, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 32'h10C, 1);
    chk("t3_head", 64'(pc), 64'h100);
    cyc(0, 0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 0, 32'h0, 1);

    // 4: flush overrides freeze while full
    cyc(0, 0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 1, 32'h204, 0);
    cyc(0, 1, 1, 1, 32'h208, 1);
    chk("t4_kill", 64'(kill_cnt), 64'd2);
    chk("t4_instr", 64'(instruction), 64'(BUBBLE));
    cyc(0, 0, 0, 0, 32'h0, 0);

    // 5: two-bit counter saturates at 3
    cyc(1, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 32'h300 + 32'(i * 8), 0);
      cyc(0, 0, 0, 1, 32'h304 + 32'(i * 8), 0);
      cyc(0, 0, 1, 1, 32'h3F0, 0);
      chk("t5_sat", 64'(kill_cnt), 64'(sat_exp[i]));
    end

    // 6: reset while full drops entries and clears the counter
    cyc(0, 0, 0, 1, 32'h400, 0);
    cyc(0, 0, 0, 1, 32'h404, 0);
    cyc(1, 0, 0, 1, 32'h408, 0);
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_kill", 64'(kill_cnt), 64'd0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      cyc(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
